// File: rtl/bsync_transmitter.sv
// BSYNC output generator: 50% duty periodic waveform with start phase offset, graceful stop,
// and ratio reload at period boundaries. Optional pulse-count auto-stop under BSYNC_TX_PULSE_COUNT_EN.
module bsync_transmitter #(
   parameter int RATIO_WIDTH = 16,
   parameter int DELAY_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   enable,
   input  logic [RATIO_WIDTH-1:0] ratio,
   input  logic [DELAY_WIDTH-1:0] delay,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   load,
   output logic                   bsync_out,
   output logic                   bsync_oe,
   output logic                   busy,
   output logic                   period_tick,
   output logic                   cfg_error,
`ifdef BSYNC_TX_PULSE_COUNT_EN
   input  logic [15:0]            pulse_count,
   output logic                   pulses_done,
`endif
   output logic [2:0]             tx_state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DELAY    = 3'd1,
      HIGH     = 3'd2,
      LOW      = 3'd3,
      STOPPING = 3'd4
   } state_t;

   localparam logic [RATIO_WIDTH-1:0] R_ONE = 1;
   localparam logic [DELAY_WIDTH-1:0] D_ONE = 1;

   state_t                 state;
   logic [RATIO_WIDTH-1:0] sh_ratio, pend_ratio, cnt;
   logic [DELAY_WIDTH-1:0] sh_delay, dcnt;
   logic                   pend_vld, stop_pend, stop_eff, auto_done;
   logic [15:0]            pc_in, pc_sh, pcnt;

`ifdef BSYNC_TX_PULSE_COUNT_EN
   assign pc_in = pulse_count;
`else
   assign pc_in = 16'd0;
`endif

   // pcnt counts periods started; the last one is allowed to finish its LOW phase
   assign auto_done = (pc_sh != 16'd0) && (pcnt == pc_sh);
   assign stop_eff  = stop | stop_pend;
   assign busy      = (state != IDLE);
   assign bsync_oe  = busy;
   assign tx_state  = state;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         bsync_out   <= 1'b0;
         period_tick <= 1'b0;
         cfg_error   <= 1'b0;
         sh_ratio    <= R_ONE;
         sh_delay    <= '0;
         pend_ratio  <= '0;
         pend_vld    <= 1'b0;
         stop_pend   <= 1'b0;
         cnt         <= '0;
         dcnt        <= '0;
         pc_sh       <= 16'd0;
         pcnt        <= 16'd0;
`ifdef BSYNC_TX_PULSE_COUNT_EN
         pulses_done <= 1'b0;
`endif
      end else begin
         period_tick <= 1'b0;
`ifdef BSYNC_TX_PULSE_COUNT_EN
         pulses_done <= 1'b0;
`endif
         if (!enable) begin
            state     <= IDLE;
            bsync_out <= 1'b0;
            pend_vld  <= 1'b0;
            stop_pend <= 1'b0;
            cnt       <= '0;
            dcnt      <= '0;
         end else begin
            if (stop && (state == HIGH || state == LOW))
               stop_pend <= 1'b1;
            case (state)
               IDLE: begin
                  bsync_out <= 1'b0;
                  if (start && !stop) begin
                     if (ratio == '0)
                        cfg_error <= 1'b1;
                     else begin
                        sh_ratio  <= ratio;
                        sh_delay  <= delay;
                        pc_sh     <= pc_in;
                        pend_vld  <= 1'b0;
                        stop_pend <= 1'b0;
                        cnt       <= '0;
                        dcnt      <= '0;
                        if (delay == '0) begin
                           state       <= HIGH;
                           bsync_out   <= 1'b1;
                           period_tick <= 1'b1;
                           pcnt        <= 16'd1;
                        end else
                           state <= DELAY;
                     end
                  end
               end
               DELAY: begin
                  if (stop)
                     state <= IDLE;
                  else if (dcnt == sh_delay - D_ONE) begin
                     state       <= HIGH;
                     bsync_out   <= 1'b1;
                     period_tick <= 1'b1;
                     pcnt        <= 16'd1;
                  end else
                     dcnt <= dcnt + D_ONE;
               end
               HIGH: begin
                  if (cnt == sh_ratio - R_ONE) begin
                     cnt       <= '0;
                     bsync_out <= 1'b0;
                     stop_pend <= 1'b0;
                     state     <= stop_eff ? STOPPING : LOW;
                  end else
                     cnt <= cnt + R_ONE;
               end
               LOW: begin
                  if (cnt == sh_ratio - R_ONE) begin
                     cnt <= '0;
                     if (stop_eff || auto_done) begin
                        state     <= IDLE;
                        stop_pend <= 1'b0;
                        pend_vld  <= 1'b0;
`ifdef BSYNC_TX_PULSE_COUNT_EN
                        pulses_done <= auto_done;
`endif
                     end else begin
                        state       <= HIGH;
                        bsync_out   <= 1'b1;
                        period_tick <= 1'b1;
                        pcnt        <= pcnt + 16'd1;
                        if (pend_vld) begin
                           sh_ratio <= pend_ratio;
                           pend_vld <= 1'b0;
                        end
                     end
                  end else
                     cnt <= cnt + R_ONE;
               end
               STOPPING: begin
                  if (cnt == sh_ratio - R_ONE) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else
                     cnt <= cnt + R_ONE;
               end
               default: begin
                  state     <= IDLE;
                  bsync_out <= 1'b0;
               end
            endcase
            // a load landing on the boundary cycle stays pending for the following boundary
            if (load && ratio == '0)
               cfg_error <= 1'b1;
            else if (load && (state == HIGH || state == LOW)) begin
               pend_ratio <= ratio;
               pend_vld   <= 1'b1;
            end
         end
      end
   end

endmodule
